// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit (access sizes, FSM states)
// and the alignment fault rule used at request acceptance.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_RESP
  } state_e;

  // Reserved size, odd halfword, or non-word-aligned word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: CPU-side request/response handshake of the load/store unit.
// master = requester (CPU pipeline), slave = load_store_unit.
interface lsu_if #(parameter int AW = 32);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_fault;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic shared by the load and store paths.
// Load: pick the byte/half lane from the memory word and extend it.
// Store: merge a byte/half into the memory word, preserving other bytes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [1:0] sz,
                                              input logic [1:0] l, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[8*l +: 8];
    h = l[1] ? rd[31:16] : rd[15:0];
    r = '0;
    case (sz)
      SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      SZ_WORD: r = rd;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] rd, input logic [15:0] wd,
                                              input logic [1:0] sz, input logic [1:0] l);
    logic [31:0] m;
    m = rd;
    case (sz)
      SZ_BYTE: m[8*l +: 8] = wd[7:0];
      SZ_HALF: begin
        if (l[1]) m[31:16] = wd;
        else      m[15:0]  = wd;
      end
      default: m = rd;
    endcase
    return m;
  endfunction

  // Both results are always available; the FSM picks which one to register.
  always_comb begin
    load_data  = load_extend(rdata, size, lo, is_unsigned);
    store_data = store_merge(rdata, wdata, size, lo);
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: converts byte/half/word loads and stores into whole-word
// accesses on an async-read / sync-write data memory. Sub-word stores use
// read-modify-write. One request outstanding at a time.
// Optional macro LSU_RANGE_CHECK_EN: word index >= DEPTH also faults.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  lsu_if.slave          bus,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_e        state;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [1:0]    lo_q;
  logic [15:0]   wdata_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic [31:0]   rdata_q;
  logic          fault_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          req_fault;
  logic [31:0]   load_data;
  logic [31:0]   store_data;

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;
  // A write registered for the cycle reset arrives in must never reach memory.
  assign mem_we    = mem_we_q & ~reset;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef LSU_RANGE_CHECK_EN
  localparam logic [AW-3:0] DEPTH_W = (AW-2)'(DEPTH);
`endif

  // Fault decision for the request currently presented on the bus.
  always_comb begin
    req_fault = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`ifdef LSU_RANGE_CHECK_EN
    if (bus.req_addr[AW-1:2] >= DEPTH_W) req_fault = 1'b1;
`endif
  end

  lsu_align u_align (
    .lo          (lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata       (mem_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // Request FSM with registered handshake and memory-side outputs.
  // Word stores launch mem_we at acceptance so the write lands in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      lo_q         <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      fault_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            we_q        <= bus.req_we;
            size_q      <= bus.req_size;
            uns_q       <= bus.req_unsigned;
            lo_q        <= bus.req_addr[1:0];
            wdata_q     <= bus.req_wdata[15:0];
            req_ready_q <= 1'b0;
            rdata_q     <= '0;
            fault_q     <= req_fault;
            if (req_fault) begin
              state        <= S_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state      <= S_EXEC;
              mem_addr_q <= {bus.req_addr[AW-1:2], 2'b00};
              if (bus.req_we && bus.req_size == SZ_WORD) begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= bus.req_wdata;
              end
            end
          end
        end
        S_EXEC: begin
          mem_we_q <= 1'b0;
          if (!we_q) begin
            rdata_q      <= load_data;
            state        <= S_RESP;
            resp_valid_q <= 1'b1;
          end else if (size_q == SZ_WORD) begin
            state        <= S_RESP;
            resp_valid_q <= 1'b1;
          end else begin
            mem_wdata_q <= store_data;
            mem_we_q    <= 1'b1;
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          mem_we_q     <= 1'b0;
          state        <= S_RESP;
          resp_valid_q <= 1'b1;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + random checks of load_store_unit against a
// byte-addressed reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem [256];
  logic [7:0]  ref_bytes [1024];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  lsu_if #(.AW(32)) bus ();

  load_store_unit #(.DEPTH(64), .AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Attached data memory: async read, sync write.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a & ~3;
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  // One complete request: model, drive, measure latency/writes, check, handshake.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic flt);
    logic        exp_fault;
    logic [31:0] exp_rd, exp_word, wa, wdat;
    longint      v;
    int          n, exp_lat, exp_we, lat, wecnt, guard;
    exp_fault = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`ifdef LSU_RANGE_CHECK_EN
    if ((a >> 2) >= 64) exp_fault = 1'b1;
`endif
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_rd = '0;
    exp_word = '0;
    if (!exp_fault && !we) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(ref_bytes[int'(a) + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      exp_rd = v[31:0];
    end
    if (!exp_fault && we) begin
      for (int i = 0; i < n; i++) ref_bytes[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
      exp_word = ref_word(int'(a));
    end
    exp_lat = exp_fault ? 1 : (we && n < 4) ? 3 : 2;
    exp_we  = (!exp_fault && we) ? 1 : 0;

    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = a;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    // Garbage on the request side must be ignored while busy.
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom);
    bus.req_size = 2'($urandom);
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    lat = 1;
    wecnt = 0;
    wa = '0;
    wdat = '0;
    while (bus.resp_valid !== 1'b1 && lat < 12) begin
      if (mem_we) begin wecnt++; wa = mem_addr; wdat = mem_wdata; end
      @(posedge clk); #1; lat++;
    end
    if (mem_we) wecnt++;
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_fault", 32'(bus.resp_fault), 32'(exp_fault));
    check("resp_rdata", bus.resp_rdata, exp_rd);
    check("mem_we_cycles", 32'(wecnt), 32'(exp_we));
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
    if (exp_we == 1) begin
      check("write_addr", wa, a & ~32'd3);
      check("write_data", wdat, exp_word);
    end
    rd = bus.resp_rdata;
    flt = bus.resp_fault;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_rdata", bus.resp_rdata, exp_rd);
      check("hold_fault", 32'(bus.resp_fault), 32'(exp_fault));
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("resp_valid_clear", 32'(bus.resp_valid), 32'd0);
    check("req_ready_back", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    logic        rwe, runs;
    logic [1:0]  rsz;
    logic [31:0] ra;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 1024; i++) ref_bytes[i] = '0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = '0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_fault", 32'(bus.resp_fault), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    // Word store / load round trip.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, flt);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, flt);
    check("lw_deadbeef", rd, 32'hDEADBEEF);

    // Byte store merge, then signed/unsigned byte loads.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 0, rd, flt);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h555555AA, 0, rd, flt);
    check("sb_merged_word", mem[4], 32'h1122AA44);
    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0, rd, flt);
    check("lb_sext", rd, 32'hFFFFFFAA);
    do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, rd, flt);
    check("lbu_zext", rd, 32'h000000AA);

    // Half store merge, then signed/unsigned half loads.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, flt);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h12348001, 0, rd, flt);
    check("sh_merged_word", mem[4], 32'h80010000);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, rd, flt);
    check("lh_sext", rd, 32'hFFFF8001);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, rd, flt);
    check("lhu_zext", rd, 32'h00008001);

    // Faults: misaligned word, misaligned half, reserved size.
    do_req(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 0, rd, flt);
    check("lw_misaligned_fault", 32'(flt), 32'd1);
    do_req(1'b1, 2'd1, 1'b0, 32'h05, 32'hFFFF, 0, rd, flt);
    check("sh_misaligned_fault", 32'(flt), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 0, rd, flt);
    check("size11_fault", 32'(flt), 32'd1);

    // Response held under backpressure.
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, rd, flt);

    // Word 0x40 is past a 64-word memory: faults only with the range check.
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 0, rd, flt);

    // Random traffic within the in-range window.
    for (int k = 0; k < 60; k++) begin
      rwe  = 1'($urandom);
      rsz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      runs = 1'($urandom);
      ra   = $urandom_range(0, 252);
      do_req(rwe, rsz, runs, ra, $urandom, $urandom_range(0, 2), rd, flt);
    end

    // Reset during WRITE of a byte store: write must be dropped.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 0, rd, flt);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h11;
    bus.req_wdata = 32'hAA;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("write_state_we", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("we_gated_by_reset", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_mem_word", mem[4], 32'h11223344);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_rdata", bus.resp_rdata, 32'd0);
    check("abort_fault", 32'(bus.resp_fault), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    check("abort_no_resp", 32'(bus.resp_valid), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, flt);
    check("abort_readback", rd, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
